// File: rtl/gp_reg_pkg.sv
// +------------------------------------------------------------------+
// | Module   : gp_reg_pkg                                             |
// | Purpose  : Shared types and constants for the general-purpose     |
// |            register bank: op encoding, default sizes and a helper |
// |            that tells which op codes actually modify a register.  |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

package gp_reg_pkg;

    localparam int c_DEFAULT_WIDTH    = 8;
    localparam int c_DEFAULT_NUM_REGS = 4;

    // Codes 110 and 111 are unassigned and behave as NOP.
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_INC = 3'b001,
        OP_DEC = 3'b010,
        OP_SHL = 3'b011,
        OP_SHR = 3'b100,
        OP_CLR = 3'b101
    } op_e;

    // True for op codes that write a result and update the flags.
    function automatic logic op_is_active(input logic [2:0] op);
        logic r_active;
        case (op)
            OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_CLR: r_active = 1'b1;
            default:                                r_active = 1'b0;
        endcase
        return r_active;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gp_register_bank_if.sv
// +------------------------------------------------------------------+
// | Module   : gp_register_bank_if                                   |
// | Purpose  : Bus/control bundle between the control sequencer       |
// |            (master) and the register bank (slave).                |
// | Ports    : bus_in/WE/wr_sel   - bus write                         |
// |            OE/rd_sel          - registered read-out request       |
// |            op_en/op/op_sel    - in-place operation                |
// |            bus_out/out_valid  - read data and its one-cycle pulse |
// |            zero/carry         - flags of the last executed op     |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

interface gp_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic [WIDTH-1:0] bus_in;
    logic             WE;
    logic [SEL_W-1:0] wr_sel;
    logic             OE;
    logic [SEL_W-1:0] rd_sel;
    logic             op_en;
    logic [2:0]       op;
    logic [SEL_W-1:0] op_sel;
    logic [WIDTH-1:0] bus_out;
    logic             out_valid;
    logic             zero;
    logic             carry;

    modport master (
        output bus_in, WE, wr_sel, OE, rd_sel, op_en, op, op_sel,
        input  bus_out, out_valid, zero, carry
    );

    modport slave (
        input  bus_in, WE, wr_sel, OE, rd_sel, op_en, op, op_sel,
        output bus_out, out_valid, zero, carry
    );
endinterface

`default_nettype wire

// File: rtl/gp_reg_alu.sv
// +------------------------------------------------------------------+
// | Module   : gp_reg_alu                                            |
// | Purpose  : Combinational in-place operation unit for one register |
// |            operand: INC/DEC/SHL/SHR/CLR with carry and zero out.  |
// | Ports    : operand   - current register value                     |
// |            op        - operation code (unassigned codes pass)     |
// |            result    - new register value                         |
// |            carry_out - carry, borrow or shifted-out bit           |
// |            zero_out  - result equals zero                         |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module gp_reg_alu
    import gp_reg_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out
);

    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result    = operand;
        carry_out = 1'b0;
        case (op_e'(op))
            // The extra top bit of the widened sum/difference is the
            // carry on FF->00 and the borrow on 00->FF.
            OP_INC: {carry_out, result} = {1'b0, operand} + c_ONE;
            OP_DEC: {carry_out, result} = {1'b0, operand} - c_ONE;
            OP_SHL: begin
                carry_out = operand[WIDTH-1];
                result    = {operand[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
                carry_out = operand[0];
                result    = {1'b0, operand[WIDTH-1:1]};
            end
            OP_CLR: begin
                carry_out = 1'b0;
                result    = '0;
            end
            default: begin
                result    = operand;
                carry_out = 1'b0;
            end
        endcase
    end

    assign zero_out = (result == '0);

endmodule

`default_nettype wire

// File: rtl/gp_register_bank.sv
// +------------------------------------------------------------------+
// | Module   : gp_register_bank                                      |
// | Purpose  : NUM_REGS general-purpose registers of WIDTH bits on    |
// |            the shared data bus: bus write, registered read-out    |
// |            and in-place ops with zero/carry flags.                |
// | Ports    : CLK   - system clock, rising edge                      |
// |            RESET - synchronous, active-high                       |
// |            bus   - slave side of gp_register_bank_if              |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module gp_register_bank
    import gp_reg_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int NUM_REGS = c_DEFAULT_NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    gp_register_bank_if.slave     bus
);

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] r_bus_out;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_carry;

    logic             w_wr_hit;
    logic             w_wr_rd_same;
    logic             w_op_exec;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_op_operand;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_zero;

    // Selects are SEL_W bits wide but the bank need not be a power of two.
    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return 32'(s) < 32'(NUM_REGS);
    endfunction

    assign w_wr_hit     = bus.WE && sel_ok(bus.wr_sel);
    assign w_wr_rd_same = w_wr_hit && (bus.wr_sel == bus.rd_sel);

    // A bus write to the op target wins: the op is dropped and the
    // flags keep their previous value.
    assign w_op_exec = bus.op_en && op_is_active(bus.op) && sel_ok(bus.op_sel)
                       && !(w_wr_hit && (bus.wr_sel == bus.op_sel));

    // Read and op-operand muxes; an out-of-range select yields zero.
    always_comb begin
        w_rd_data    = '0;
        w_op_operand = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_sel == SEL_W'(i)) w_rd_data    = r_regs[i];
            if (bus.op_sel == SEL_W'(i)) w_op_operand = r_regs[i];
        end
    end

    gp_reg_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .operand   (w_op_operand),
        .op        (bus.op),
        .result    (w_alu_result),
        .carry_out (w_alu_carry),
        .zero_out  (w_alu_zero)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_regs[gi] <= '0;
            end else if (w_wr_hit && (bus.wr_sel == SEL_W'(gi))) begin
                r_regs[gi] <= bus.bus_in;
            end else if (w_op_exec && (bus.op_sel == SEL_W'(gi))) begin
                r_regs[gi] <= w_alu_result;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_bus_out   <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_out_valid <= bus.OE;
            if (bus.OE) begin
                // Write-through returns the value landing this edge; a
                // pending op on the same register is not forwarded.
                r_bus_out <= w_wr_rd_same ? bus.bus_in : w_rd_data;
            end
            if (w_op_exec) begin
                r_zero  <= w_alu_zero;
                r_carry <= w_alu_carry;
            end
        end
    end

    assign bus.bus_out   = r_bus_out;
    assign bus.out_valid = r_out_valid;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_gp_register_bank.sv
// +------------------------------------------------------------------+
// | Module   : tb_gp_register_bank                                   |
// | Purpose  : Directed self-checking bench for gp_register_bank.     |
// |            dut4 uses the default 4-register bank, dut3 a 3-entry  |
// |            bank to exercise out-of-range selects.                 |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gp_register_bank;
    import gp_reg_pkg::*;

    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_fail;

    gp_register_bank_if #(.WIDTH(8), .SEL_W(2)) if4 ();
    gp_register_bank_if #(.WIDTH(8), .SEL_W(2)) if3 ();

    gp_register_bank #(.WIDTH(8), .NUM_REGS(4)) dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if4.slave)
    );

    gp_register_bank #(.WIDTH(8), .NUM_REGS(3)) dut3 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if3.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        if4.bus_in = '0; if4.WE = 0; if4.wr_sel = '0; if4.OE = 0; if4.rd_sel = '0;
        if4.op_en = 0; if4.op = OP_NOP; if4.op_sel = '0;
        if3.bus_in = '0; if3.WE = 0; if3.wr_sel = '0; if3.OE = 0; if3.rd_sel = '0;
        if3.op_en = 0; if3.op = OP_NOP; if3.op_sel = '0;
    endtask

    task automatic wr4(input logic [1:0] s, input logic [7:0] d);
        idle(); if4.WE = 1; if4.wr_sel = s; if4.bus_in = d; tick(); idle();
    endtask

    task automatic rd4(input logic [1:0] s);
        idle(); if4.OE = 1; if4.rd_sel = s; tick(); idle();
    endtask

    task automatic op4(input logic [1:0] s, input logic [2:0] o);
        idle(); if4.op_en = 1; if4.op_sel = s; if4.op = o; tick(); idle();
    endtask

    task automatic wr3(input logic [1:0] s, input logic [7:0] d);
        idle(); if3.WE = 1; if3.wr_sel = s; if3.bus_in = d; tick(); idle();
    endtask

    task automatic rd3(input logic [1:0] s);
        idle(); if3.OE = 1; if3.rd_sel = s; tick(); idle();
    endtask

    task automatic op3(input logic [1:0] s, input logic [2:0] o);
        idle(); if3.op_en = 1; if3.op_sel = s; if3.op = o; tick(); idle();
    endtask

    task automatic test_reset();
        wr4(2'd2, 8'hA5);
        wr4(2'd0, 8'hFF);
        op4(2'd0, OP_INC);
        rd4(2'd2);
        n_cmp++;
        if ({if4.bus_out, if4.out_valid, if4.zero, if4.carry} !== {8'hA5, 3'b111}) begin
            $display("FAIL pre_reset: got bus_out=%h v=%b z=%b c=%b want A5 1 1 1",
                     if4.bus_out, if4.out_valid, if4.zero, if4.carry);
            n_fail++;
        end
        // Reset together with every other request active.
        idle();
        RESET = 1;
        if4.OE = 1; if4.rd_sel = 2'd2;
        if4.WE = 1; if4.wr_sel = 2'd1; if4.bus_in = 8'h5A;
        if4.op_en = 1; if4.op_sel = 2'd3; if4.op = OP_DEC;
        tick();
        RESET = 0;
        idle();
        n_cmp++;
        if (if4.bus_out !== 8'h00) begin
            $display("FAIL reset_bus_out: got %h want 00", if4.bus_out); n_fail++;
        end
        n_cmp++;
        if (if4.out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); n_fail++;
        end
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b00) begin
            $display("FAIL reset_flags: got z=%b c=%b want 0 0", if4.zero, if4.carry); n_fail++;
        end
        for (int s = 0; s < 4; s++) begin
            rd4(2'(s));
            n_cmp++;
            if ({if4.bus_out, if4.out_valid} !== {8'h00, 1'b1}) begin
                $display("FAIL reset_reg%0d: got %h v=%b want 00 1", s, if4.bus_out, if4.out_valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_write_read();
        wr4(2'd1, 8'h3C);
        n_cmp++;
        if (if4.out_valid !== 1'b0) begin
            $display("FAIL wr_no_valid: got %b want 0", if4.out_valid); n_fail++;
        end
        rd4(2'd1);
        n_cmp++;
        if ({if4.bus_out, if4.out_valid} !== {8'h3C, 1'b1}) begin
            $display("FAIL rd_data: got %h v=%b want 3C 1", if4.bus_out, if4.out_valid); n_fail++;
        end
        tick();
        n_cmp++;
        if ({if4.bus_out, if4.out_valid} !== {8'h3C, 1'b0}) begin
            $display("FAIL rd_hold: got %h v=%b want 3C 0", if4.bus_out, if4.out_valid); n_fail++;
        end
    endtask

    task automatic test_wrap();
        wr4(2'd0, 8'hFF);
        op4(2'd0, OP_INC);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b11) begin
            $display("FAIL inc_wrap_flags: got z=%b c=%b want 1 1", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd0);
        n_cmp++;
        if (if4.bus_out !== 8'h00) begin
            $display("FAIL inc_wrap_val: got %h want 00", if4.bus_out); n_fail++;
        end
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b11) begin
            $display("FAIL flags_hold_on_read: got z=%b c=%b want 1 1", if4.zero, if4.carry); n_fail++;
        end
        op4(2'd0, OP_DEC);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b01) begin
            $display("FAIL dec_wrap_flags: got z=%b c=%b want 0 1", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd0);
        n_cmp++;
        if (if4.bus_out !== 8'hFF) begin
            $display("FAIL dec_wrap_val: got %h want FF", if4.bus_out); n_fail++;
        end
        wr4(2'd1, 8'h41);
        op4(2'd1, OP_INC);
        rd4(2'd1);
        n_cmp++;
        if ({if4.bus_out, if4.zero, if4.carry} !== {8'h42, 2'b00}) begin
            $display("FAIL inc_plain: got %h z=%b c=%b want 42 0 0", if4.bus_out, if4.zero, if4.carry);
            n_fail++;
        end
    endtask

    task automatic test_shifts();
        wr4(2'd3, 8'h81);
        op4(2'd3, OP_SHL);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b01) begin
            $display("FAIL shl_flags: got z=%b c=%b want 0 1", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd3);
        n_cmp++;
        if (if4.bus_out !== 8'h02) begin
            $display("FAIL shl_val: got %h want 02", if4.bus_out); n_fail++;
        end
        op4(2'd3, OP_SHR);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b00) begin
            $display("FAIL shr_flags: got z=%b c=%b want 0 0", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd3);
        n_cmp++;
        if (if4.bus_out !== 8'h01) begin
            $display("FAIL shr_val: got %h want 01", if4.bus_out); n_fail++;
        end
        // SHR of 01 shifts the one out: result 0, carry 1.
        wr4(2'd2, 8'h01);
        op4(2'd2, OP_SHR);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b11) begin
            $display("FAIL shr_out_flags: got z=%b c=%b want 1 1", if4.zero, if4.carry); n_fail++;
        end
        wr4(2'd2, 8'h5A);
        op4(2'd2, OP_CLR);
        rd4(2'd2);
        n_cmp++;
        if ({if4.bus_out, if4.zero, if4.carry} !== {8'h00, 2'b10}) begin
            $display("FAIL clr: got %h z=%b c=%b want 00 1 0", if4.bus_out, if4.zero, if4.carry);
            n_fail++;
        end
    endtask

    task automatic test_collision();
        // r0 is FF from the wrap test: INC leaves zero=1, carry=1.
        op4(2'd0, OP_INC);
        wr4(2'd2, 8'h10);
        idle();
        if4.WE = 1; if4.wr_sel = 2'd2; if4.bus_in = 8'h77;
        if4.OE = 1; if4.rd_sel = 2'd2;
        if4.op_en = 1; if4.op_sel = 2'd2; if4.op = OP_INC;
        tick();
        idle();
        n_cmp++;
        if ({if4.bus_out, if4.out_valid} !== {8'h77, 1'b1}) begin
            $display("FAIL coll3_bus: got %h v=%b want 77 1", if4.bus_out, if4.out_valid); n_fail++;
        end
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b11) begin
            $display("FAIL coll3_flags: got z=%b c=%b want 1 1", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd2);
        n_cmp++;
        if (if4.bus_out !== 8'h77) begin
            $display("FAIL coll3_reg: got %h want 77", if4.bus_out); n_fail++;
        end
        // Read and op on the same register: read returns the pre-op value.
        wr4(2'd3, 8'h01);
        idle();
        if4.OE = 1; if4.rd_sel = 2'd3;
        if4.op_en = 1; if4.op_sel = 2'd3; if4.op = OP_SHL;
        tick();
        idle();
        n_cmp++;
        if ({if4.bus_out, if4.zero, if4.carry} !== {8'h01, 2'b00}) begin
            $display("FAIL rd_op_pre: got %h z=%b c=%b want 01 0 0", if4.bus_out, if4.zero, if4.carry);
            n_fail++;
        end
        rd4(2'd3);
        n_cmp++;
        if (if4.bus_out !== 8'h02) begin
            $display("FAIL rd_op_post: got %h want 02", if4.bus_out); n_fail++;
        end
        // Write and read on different registers in one cycle.
        idle();
        if4.WE = 1; if4.wr_sel = 2'd1; if4.bus_in = 8'hC3;
        if4.OE = 1; if4.rd_sel = 2'd2;
        tick();
        idle();
        n_cmp++;
        if (if4.bus_out !== 8'h77) begin
            $display("FAIL wr_rd_indep: got %h want 77", if4.bus_out); n_fail++;
        end
        rd4(2'd1);
        n_cmp++;
        if (if4.bus_out !== 8'hC3) begin
            $display("FAIL wr_rd_indep_reg: got %h want C3", if4.bus_out); n_fail++;
        end
    endtask

    task automatic test_nop();
        // Flags are currently z=0 c=0 and r3=02; an undefined code on r3 must do nothing.
        op4(2'd0, OP_INC);
        op4(2'd3, 3'b110);
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b00) begin
            $display("FAIL nop_code_flags: got z=%b c=%b want 0 0", if4.zero, if4.carry); n_fail++;
        end
        wr4(2'd3, 8'h00);
        op4(2'd3, OP_NOP);
        idle(); if4.op = OP_INC; if4.op_sel = 2'd3; tick(); idle();
        n_cmp++;
        if ({if4.zero, if4.carry} !== 2'b00) begin
            $display("FAIL op_en_low_flags: got z=%b c=%b want 0 0", if4.zero, if4.carry); n_fail++;
        end
        rd4(2'd3);
        n_cmp++;
        if (if4.bus_out !== 8'h00) begin
            $display("FAIL nop_reg: got %h want 00", if4.bus_out); n_fail++;
        end
    endtask

    task automatic test_out_of_range();
        wr3(2'd0, 8'h11);
        wr3(2'd1, 8'h22);
        wr3(2'd2, 8'hFF);
        op3(2'd2, OP_INC);
        wr3(2'd3, 8'h55);
        rd3(2'd3);
        n_cmp++;
        if ({if3.bus_out, if3.out_valid} !== {8'h00, 1'b1}) begin
            $display("FAIL oor_read: got %h v=%b want 00 1", if3.bus_out, if3.out_valid); n_fail++;
        end
        op3(2'd3, OP_CLR);
        n_cmp++;
        if ({if3.zero, if3.carry} !== 2'b11) begin
            $display("FAIL oor_op_flags: got z=%b c=%b want 1 1", if3.zero, if3.carry); n_fail++;
        end
        idle();
        if3.WE = 1; if3.wr_sel = 2'd3; if3.bus_in = 8'h99;
        if3.OE = 1; if3.rd_sel = 2'd3;
        tick();
        idle();
        n_cmp++;
        if ({if3.bus_out, if3.out_valid} !== {8'h00, 1'b1}) begin
            $display("FAIL oor_write_through: got %h v=%b want 00 1", if3.bus_out, if3.out_valid);
            n_fail++;
        end
        rd3(2'd0);
        n_cmp++;
        if (if3.bus_out !== 8'h11) begin
            $display("FAIL oor_r0: got %h want 11", if3.bus_out); n_fail++;
        end
        rd3(2'd1);
        n_cmp++;
        if (if3.bus_out !== 8'h22) begin
            $display("FAIL oor_r1: got %h want 22", if3.bus_out); n_fail++;
        end
        rd3(2'd2);
        n_cmp++;
        if (if3.bus_out !== 8'h00) begin
            $display("FAIL oor_r2: got %h want 00", if3.bus_out); n_fail++;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle();
        RESET = 1;
        tick();
        tick();
        RESET = 0;
        test_reset();
        test_write_read();
        test_wrap();
        test_shifts();
        test_collision();
        test_nop();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
